// File: rtl/ff_byte_stuffer_if.sv
// ---------------------------------------------------------------------------
// ff_byte_stuffer_if
//
// Word-stream bus carrying up to four bytes per beat, MSB first
// (data[31:24] is the first byte). A beat transfers on a clock edge where
// valid=1 and hold=0.
//
//   data    32  payload bytes, MSB first
//   nbytes   3  number of valid bytes in data (0-4)
//   tlast    1  last beat of a packet
//   valid    1  beat present (driven by the master)
//   hold     1  stall (driven by the slave)
//
// Modports:
//   master  produces beats (drives data/nbytes/tlast/valid, samples hold)
//   slave   consumes beats (samples data/nbytes/tlast/valid, drives hold)
// ---------------------------------------------------------------------------
interface ff_byte_stuffer_if;
  logic [31:0] data;
  logic [2:0]  nbytes;
  logic        tlast;
  logic        valid;
  logic        hold;

  modport master (
    output data,
    output nbytes,
    output tlast,
    output valid,
    input  hold
  );

  modport slave (
    input  data,
    input  nbytes,
    input  tlast,
    input  valid,
    output hold
  );
endinterface : ff_byte_stuffer_if

// File: rtl/ff_byte_stuffer.sv
// ---------------------------------------------------------------------------
// ff_byte_stuffer
//
// JPEG entropy-coded-segment byte stuffer. Sits behind the entropy bit
// packer: accepts words of 1-4 bytes (0 bytes allowed only on tlast),
// inserts a 0x00 after every 0xFF data byte, and repacks the resulting
// byte stream into full 32-bit words. Only the last word of a packet may be
// partial; it is marked with tlast.
//
// Ports:
//   clk      clock
//   resetn   synchronous, active-low reset; discards any queued bytes
//   in_if    slave side : packer words in, hold stalls the packer
//   out_if   master side: stuffed words out, hold stalls this block
//
// Parameters:
//   BUF_BYTES  depth of the internal byte queue. Must be >= 12
//              (>= 14 when JPEG_EOI_APPEND_EN is defined).
//
// Build option:
//   JPEG_EOI_APPEND_EN  when defined, the EOI marker FF D9 (never stuffed)
//                       is appended after the final data byte of each
//                       packet and is carried in the packet's last word.
//
// Structure:
//   stuffing network (comb) -> circular byte queue -> output register
//   A two-state FSM (FILL / FLUSH) tracks whether the current packet's last
//   input word has been accepted and the queue is being drained to tlast.
// ---------------------------------------------------------------------------
module ff_byte_stuffer #(
  parameter int BUF_BYTES = 16
) (
  input  logic               clk,
  input  logic               resetn,
  ff_byte_stuffer_if.slave   in_if,
  ff_byte_stuffer_if.master  out_if
);

  // Largest number of bytes a single accepted input word can enqueue.
`ifdef JPEG_EOI_APPEND_EN
  localparam int IN_MAX = 10;           // 4 bytes stuffed to 8, plus FF D9
`else
  localparam int IN_MAX = 8;            // 4 bytes stuffed to 8
`endif

  localparam int PW = $clog2(BUF_BYTES);       // queue pointer width
  localparam int CW = $clog2(BUF_BYTES + 1);   // queue count width (0..BUF_BYTES)

  // The queue refuses input once a worst-case word might not fit.
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(BUF_BYTES - IN_MAX);
  localparam logic [PW:0]   DEPTH      = (PW + 1)'(BUF_BYTES);

  typedef enum logic {
    ST_FILL,   // collecting packet bytes, only full words leave
    ST_FLUSH   // tlast accepted, draining the remainder as the tlast word
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem [BUF_BYTES];

  logic [31:0]     out_data_q;
  logic [2:0]      out_nbytes_q;
  logic            out_tlast_q;
  logic            out_valid_q;

  logic [8*IN_MAX-1:0] stuff_vec;   // stuffed bytes, left-aligned, oldest first
  logic [3:0]          stuff_len;
  logic [3:0]          push_len;
  logic [2:0]          pop_len;

  logic            hold_int;
  logic            accept;
  logic            load_en;
  logic            ld_flush;
  logic            ld_normal;
  logic [2:0]      ld_nbytes;
  logic [31:0]     ld_data;
  logic [7:0]      rd_byte [4];

  // Circular index helper: idx is at most 2*BUF_BYTES-1, so one subtract wraps.
  function automatic logic [PW-1:0] wrap(input logic [PW:0] idx);
    if (idx >= DEPTH) begin
      return PW'(idx - DEPTH);
    end
    return idx[PW-1:0];
  endfunction

  assign in_if.hold    = hold_int;
  assign out_if.data   = out_data_q;
  assign out_if.nbytes = out_nbytes_q;
  assign out_if.tlast  = out_tlast_q;
  assign out_if.valid  = out_valid_q;

  // -------------------------------------------------------------------------
  // Stuffing network: expand the valid input bytes into a left-aligned byte
  // vector. Bytes are shifted in from the right as they are produced, then
  // the whole vector is shifted left so the first byte lands in the top lane.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable of a combinational block gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    stuff_vec = '0;
    stuff_len = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < in_if.nbytes) begin
        stuff_vec = {stuff_vec[8*IN_MAX-9:0], in_if.data[31-8*i -: 8]};
        stuff_len = stuff_len + 4'd1;
        if (in_if.data[31-8*i -: 8] == 8'hFF) begin
          stuff_vec = {stuff_vec[8*IN_MAX-9:0], 8'h00};
          stuff_len = stuff_len + 4'd1;
        end
      end
    end
`ifdef JPEG_EOI_APPEND_EN
    // The marker bypasses stuffing: FF D9 must reach the stream verbatim.
    if (in_if.tlast) begin
      stuff_vec = {stuff_vec[8*IN_MAX-17:0], 16'hFFD9};
      stuff_len = stuff_len + 4'd2;
    end
`endif
    stuff_vec = stuff_vec << (8 * (IN_MAX - int'(stuff_len)));
  end

  // -------------------------------------------------------------------------
  // Queue read side: the four oldest bytes, zero-masked beyond the number
  // actually being loaded so a partial tlast word has clean low lanes.
  // -------------------------------------------------------------------------
  always_comb begin
    ld_data = '0;
    for (int k = 0; k < 4; k++) begin
      rd_byte[k] = mem[wrap({1'b0, rd_ptr_q} + (PW + 1)'(k))];
      if (3'(k) < ld_nbytes) begin
        ld_data[31-8*k -: 8] = rd_byte[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control: FSM next state, upstream stall, and output-register load
  // decision. Everything keys off registered count/state, so a same-cycle
  // pop never relaxes in_hold.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hold_int  = (state_q == ST_FLUSH) || (count_q > HOLD_LIMIT);
    accept    = in_if.valid && !hold_int;
    push_len  = accept ? stuff_len : 4'd0;

    load_en   = !(out_valid_q && out_if.hold);
    // With a flush pending, a remainder of 0..4 bytes is the packet's final
    // word; exactly 4 left gives a full word that still carries tlast.
    ld_flush  = (state_q == ST_FLUSH) && (count_q <= CW'(4));
    ld_normal = !ld_flush && (count_q >= CW'(4));
    ld_nbytes = 3'd0;
    if (ld_flush) begin
      ld_nbytes = count_q[2:0];
    end else if (ld_normal) begin
      ld_nbytes = 3'd4;
    end
    pop_len = load_en ? ld_nbytes : 3'd0;

    if (accept && in_if.tlast) begin
      state_d = ST_FLUSH;
    end else if (load_en && ld_flush) begin
      state_d = ST_FILL;
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage
  // -------------------------------------------------------------------------
  // NOTE: the byte array carries no reset; bytes are only ever read below
  // count_q, which is reset, so stale contents are unobservable.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < IN_MAX; k++) begin
        if (4'(k) < stuff_len) begin
          mem[wrap({1'b0, wr_ptr_q} + (PW + 1)'(k))] <= stuff_vec[8*(IN_MAX-1-k) +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State, pointers, count and output register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_FILL;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      out_tlast_q  <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_q + CW'(push_len) - CW'(pop_len);
      wr_ptr_q <= wrap({1'b0, wr_ptr_q} + (PW + 1)'(push_len));
      rd_ptr_q <= wrap({1'b0, rd_ptr_q} + (PW + 1)'(pop_len));
      // A presented-but-stalled word stays frozen; otherwise reload every edge.
      if (load_en) begin
        out_valid_q  <= ld_flush || ld_normal;
        out_tlast_q  <= ld_flush;
        out_nbytes_q <= ld_nbytes;
        out_data_q   <= ld_data;
      end
    end
  end

endmodule : ff_byte_stuffer
